weight_buffer_pp: RTL and testbench

Parametrised, double-buffered (ping-pong) weight buffer feeding the convolution PE array. It collects NUM_RDATA position beats of NUM_CHANNEL-channel weights for each of NUM_KERNEL kernels into a load bank while the other bank is presented to the PEs. A bank can be held for any number of requests (weight reuse) and is released only on an explicit last-use request. Back-pressure and an overflow flag are provided toward the weight loader.

---
 rtl/weight_buffer_pp.sv | 111 +++++++++++
 tb/tb_weight_buffer_pp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_pp.sv
// weight_buffer_pp: double-buffered (ping-pong) weight buffer for the PE array.
// One bank fills with per-kernel position beats while the other is presented
// to the PEs. A read bank is held across any number of requests and is only
// released when a request arrives together with i_data_last.
module weight_buffer_pp #(
  parameter int DAT_WIDTH   = 8,
  parameter int NUM_KERNEL  = 4,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_RDATA   = 3,
  localparam int BEAT  = DAT_WIDTH * NUM_CHANNEL,
  localparam int SLICE = BEAT * NUM_RDATA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_KERNEL*BEAT-1:0]   i_data,
  input  logic [NUM_KERNEL-1:0]        i_data_val,
  input  logic                         i_data_req,
  input  logic                         i_data_last,
  output logic [NUM_KERNEL*SLICE-1:0]  o_data,
  output logic                         o_data_val,
  output logic                         o_load_rdy,
  output logic [1:0]                   o_bank_full,
  output logic                         o_ovf
);

  // Counter must be able to hold NUM_RDATA itself ("kernel complete").
  localparam int CNT_W = $clog2(NUM_RDATA + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_RDATA);

  // Packed so that a bank flattens directly into the o_data layout:
  // kernel k at [(k+1)*SLICE-1 : k*SLICE], position p at [(p+1)*BEAT-1 : p*BEAT].
  logic [1:0][NUM_KERNEL-1:0][NUM_RDATA-1:0][BEAT-1:0] data_q, data_d;
  logic [1:0][NUM_KERNEL-1:0][CNT_W-1:0]               cnt_q, cnt_d;
  logic [1:0]                                          full_q, full_d;
  logic                                                wr_bank_q, wr_bank_d;
  logic                                                rd_bank_q, rd_bank_d;
  logic                                                ovf_q, ovf_d;
  logic                                                all_done;

  assign o_load_rdy  = ~full_q[wr_bank_q];
  assign o_data_val  = full_q[rd_bank_q] & i_data_req;
  assign o_data      = data_q[rd_bank_q];
  assign o_bank_full = full_q;
  assign o_ovf       = ovf_q;

  // Next-state: per-kernel beat capture, full detection, bank swap and release.
  always_comb begin
    data_d    = data_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = ovf_q;
    all_done  = 1'b1;

    for (int k = 0; k < NUM_KERNEL; k++) begin
      if (i_data_val[k]) begin
        if (o_load_rdy && (cnt_q[wr_bank_q][k] != CNT_MAX)) begin
          for (int p = 0; p < NUM_RDATA; p++) begin
            if (cnt_q[wr_bank_q][k] == CNT_W'(p)) begin
              data_d[wr_bank_q][k][p] = i_data[k*BEAT +: BEAT];
            end
          end
          cnt_d[wr_bank_q][k] = cnt_q[wr_bank_q][k] + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (cnt_d[wr_bank_q][k] != CNT_MAX) begin
        all_done = 1'b0;
      end
    end

    if (o_load_rdy && all_done) begin
      full_d[wr_bank_q] = 1'b1;
    end

    // Swap looks only at registered flags, so a freshly released bank
    // becomes the write target one edge after its release.
    if (full_q[wr_bank_q] && !full_q[~wr_bank_q]) begin
      wr_bank_d = ~wr_bank_q;
    end

    // Release never collides with a write: writes only go to a non-full bank.
    if (o_data_val && i_data_last) begin
      full_d[rd_bank_q] = 1'b0;
      cnt_d[rd_bank_q]  = '0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      cnt_q     <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_weight_buffer_pp.sv
// tb_weight_buffer_pp: directed bench for the ping-pong weight buffer.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_weight_buffer_pp;

  localparam int DAT_WIDTH   = 8;
  localparam int NUM_KERNEL  = 4;
  localparam int NUM_CHANNEL = 3;
  localparam int NUM_RDATA   = 3;
  localparam int BEAT        = DAT_WIDTH * NUM_CHANNEL;
  localparam int SLICE       = BEAT * NUM_RDATA;

  localparam logic [71:0] SLICE_A = 72'h070809_040506_010203;
  localparam logic [71:0] SLICE_B = 72'h333333_222222_111111;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_KERNEL*BEAT-1:0]  i_data;
  logic [NUM_KERNEL-1:0]       i_data_val;
  logic                        i_data_req;
  logic                        i_data_last;
  logic [NUM_KERNEL*SLICE-1:0] o_data;
  logic                        o_data_val;
  logic                        o_load_rdy;
  logic [1:0]                  o_bank_full;
  logic                        o_ovf;

  int assertCount = 0;
  int failCount   = 0;

  weight_buffer_pp #(
    .DAT_WIDTH  (DAT_WIDTH),
    .NUM_KERNEL (NUM_KERNEL),
    .NUM_CHANNEL(NUM_CHANNEL),
    .NUM_RDATA  (NUM_RDATA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .i_data_req (i_data_req),
    .i_data_last(i_data_last),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .o_load_rdy (o_load_rdy),
    .o_bank_full(o_bank_full),
    .o_ovf      (o_ovf)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [319:0] actual,
                             input logic [319:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs (same beat to every selected kernel), let it settle
  task automatic applyStimulus(input logic [3:0] val, input logic [23:0] beat,
                               input logic req, input logic last);
    i_data      = {4{beat}};
    i_data_val  = val;
    i_data_req  = req;
    i_data_last = last;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every kernel slice holding the same value
  function automatic logic [287:0] allK(input logic [71:0] s);
    return {4{s}};
  endfunction

  // Expected reset outputs (req held high so o_data_val must be forced low by empty banks)
  task automatic checkReset(input string tag);
    checkOutput({tag, "_data"}, o_data, '0);
    checkOutput({tag, "_val"}, o_data_val, 1'b0);
    checkOutput({tag, "_rdy"}, o_load_rdy, 1'b1);
    checkOutput({tag, "_full"}, o_bank_full, 2'b00);
    checkOutput({tag, "_ovf"}, o_ovf, 1'b0);
  endtask

  // Asynchronous reset pulse between edges, checked while still asserted
  task automatic pulseReset(input string tag);
    i_data_val = '0;
    i_data_req = 1'b1;
    i_data_last = 1'b0;
    rst = 1'b0;
    #1;
    checkReset(tag);
    #1;
    rst = 1'b1;
    tick();
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rst = 1'b1;
    i_data = '0;
    i_data_val = '0;
    i_data_req = 1'b1;
    i_data_last = 1'b0;
    #1 rst = 1'b0;
    #2;
    checkReset("rst0");
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Single fill with req/last held high: valid exactly in cycle 4
    applyStimulus(4'hF, 24'h010203, 1'b1, 1'b1);
    checkOutput("A_val_c1", o_data_val, 1'b0);
    tick();
    checkOutput("A_data_c1", o_data, allK(72'h010203));
    applyStimulus(4'hF, 24'h040506, 1'b1, 1'b1);
    checkOutput("A_val_c2", o_data_val, 1'b0);
    tick();
    applyStimulus(4'hF, 24'h070809, 1'b1, 1'b1);
    checkOutput("A_val_c3", o_data_val, 1'b0);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b1);
    checkOutput("A_val_c4", o_data_val, 1'b1);
    checkOutput("A_data_c4", o_data, allK(SLICE_A));
    checkOutput("A_full_c4", o_bank_full, 2'b01);
    checkOutput("A_rdy_c4", o_load_rdy, 1'b0);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b1);
    checkOutput("A_val_c5", o_data_val, 1'b0);
    checkOutput("A_full_c5", o_bank_full, 2'b00);
    checkOutput("A_rdy_c5", o_load_rdy, 1'b1);
    checkOutput("A_data_c5", o_data, '0);
    tick();

    // Reuse: bank1 fills, five keep-requests, then release on the sixth
    applyStimulus(4'hF, 24'h010203, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h040506, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h070809, 1'b0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, 24'h0, 1'b1, 1'b0);
      checkOutput($sformatf("B_val_%0d", i), o_data_val, 1'b1);
      checkOutput($sformatf("B_data_%0d", i), o_data, allK(SLICE_A));
      tick();
    end
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b1);
    checkOutput("B_val_last", o_data_val, 1'b1);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("B_val_after", o_data_val, 1'b0);
    checkOutput("B_full_after", o_bank_full, 2'b00);
    checkOutput("B_data_kept", o_data, allK(SLICE_A));
    tick();

    // Ping-pong back-pressure: fill both banks, overflow, release bank0
    applyStimulus(4'hF, 24'h010203, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h040506, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h070809, 1'b0, 1'b0); tick();
    applyStimulus(4'h0, 24'h0, 1'b0, 1'b0);
    checkOutput("C_bubble_rdy", o_load_rdy, 1'b0);
    checkOutput("C_bubble_full", o_bank_full, 2'b01);
    tick();
    applyStimulus(4'hF, 24'h111111, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h222222, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h333333, 1'b0, 1'b0);
    tick();
    applyStimulus(4'hF, 24'hFFFFFF, 1'b0, 1'b0);
    checkOutput("C_full_11", o_bank_full, 2'b11);
    checkOutput("C_rdy_0", o_load_rdy, 1'b0);
    checkOutput("C_ovf_pre", o_ovf, 1'b0);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b1);
    checkOutput("C_ovf_set", o_ovf, 1'b1);
    checkOutput("C_data_b0", o_data, allK(SLICE_A));
    checkOutput("C_val_rel0", o_data_val, 1'b1);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b0, 1'b0);
    checkOutput("C_data_b1", o_data, allK(SLICE_B));
    checkOutput("C_rdy_wait", o_load_rdy, 1'b0);
    checkOutput("C_full_10", o_bank_full, 2'b10);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b1);
    checkOutput("C_rdy_back", o_load_rdy, 1'b1);
    checkOutput("C_val_rel1", o_data_val, 1'b1);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b0, 1'b0);
    checkOutput("C_full_00", o_bank_full, 2'b00);
    checkOutput("C_ovf_sticky", o_ovf, 1'b1);

    pulseReset("rst1");

    // Skewed kernels: kernel 3 is four cycles late, kernel 0 gets a stray 4th beat
    applyStimulus(4'b0111, 24'h010203, 1'b1, 1'b0); tick();
    applyStimulus(4'b0111, 24'h040506, 1'b1, 1'b0); tick();
    applyStimulus(4'b0111, 24'h070809, 1'b1, 1'b0); tick();
    applyStimulus(4'b0001, 24'hFFFFFF, 1'b1, 1'b0);
    checkOutput("D_val_skew", o_data_val, 1'b0);
    checkOutput("D_data_skew", o_data, {72'h0, SLICE_A, SLICE_A, SLICE_A});
    tick();
    checkOutput("D_ovf", o_ovf, 1'b1);
    checkOutput("D_data_k0", o_data, {72'h0, SLICE_A, SLICE_A, SLICE_A});
    applyStimulus(4'b1000, 24'h010203, 1'b1, 1'b0);
    checkOutput("D_val_k3a", o_data_val, 1'b0);
    tick();
    applyStimulus(4'b1000, 24'h040506, 1'b1, 1'b0);
    checkOutput("D_val_k3b", o_data_val, 1'b0);
    tick();
    applyStimulus(4'b1000, 24'h070809, 1'b1, 1'b0);
    checkOutput("D_val_k3c", o_data_val, 1'b0);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b1);
    checkOutput("D_val_full", o_data_val, 1'b1);
    checkOutput("D_data_full", o_data, allK(SLICE_A));
    tick();

    // Mid-fill reset: two beats, reset, then three fresh beats needed
    applyStimulus(4'hF, 24'h010203, 1'b0, 1'b0); tick();
    applyStimulus(4'hF, 24'h040506, 1'b0, 1'b0); tick();
    pulseReset("rst2");
    applyStimulus(4'hF, 24'h111111, 1'b1, 1'b0); tick();
    applyStimulus(4'hF, 24'h222222, 1'b1, 1'b0);
    checkOutput("E_val_1", o_data_val, 1'b0);
    tick();
    applyStimulus(4'hF, 24'h333333, 1'b1, 1'b0);
    checkOutput("E_val_2", o_data_val, 1'b0);
    tick();
    applyStimulus(4'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("E_val_3", o_data_val, 1'b1);
    checkOutput("E_data", o_data, allK(SLICE_B));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
